// File: rtl/cipher_pkg.sv
// Shared Feistel cipher definition used by both the encryptor and the decryptor:
// round count, rotation constants, key schedule, round function and FSM encoding.
package cipher_pkg;

   localparam int ROUNDS       = 32;
   localparam int F_ROT        = 13;
   localparam int KEY_ROT_STEP = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // The upper half of {x, x} shifted left is the left rotation of x.
   function automatic logic [63:0] rotl64(input logic [63:0] x, input logic [5:0] n);
      logic [127:0] dbl;
      dbl = {x, x} << n;
      return dbl[127:64];
   endfunction

   function automatic logic [63:0] round_key(input logic [63:0] k, input logic [4:0] i);
      logic [6:0] prod;
      prod = 7'(i) * 7'(KEY_ROT_STEP);
      return rotl64(k, prod[5:0]) ^ {59'd0, i};
   endfunction

   function automatic logic [63:0] round_f(input logic [63:0] x, input logic [63:0] k);
      logic [63:0] sum;
      sum = x + k;
      return rotl64(sum, 6'(F_ROT)) ^ x;
   endfunction

endpackage

// File: rtl/feistel_round_dec.sv
// One combinational Feistel decrypt step: (L, R) -> (R ^ F(L, K), L).
module feistel_round_dec
   import cipher_pkg::*;
(
   input  logic [63:0] l,
   input  logic [63:0] r,
   input  logic [63:0] k,
   output logic [63:0] l_next,
   output logic [63:0] r_next
);

   assign l_next = r ^ round_f(l, k);
   assign r_next = l;

endmodule

// File: rtl/decryption_core.sv
// Iterative 32-round Feistel decryptor, one round per clock, valid/ready on both sides.
// Optional completed-block counter enabled by DECRYPTION_BLOCK_COUNT_EN.
module decryption_core
   import cipher_pkg::*;
(
   input  logic         sys_clk,
   input  logic         sys_rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [0:127] cipher,
   input  logic [0:63]  key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [0:127] plain,
   output logic         busy,
   output logic [15:0]  block_count
);

   // Handshake: a transfer happens on any rising edge where valid and ready are
   // both high; valid holds its data until that edge, ready depends only on state.
   state_t      state, state_next;
   logic [63:0] l_q, r_q, key_q;
   logic [4:0]  round_q;
   logic [63:0] round_k, l_next, r_next;

   assign round_k = round_key(key_q, round_q);

   feistel_round_dec u_round (
      .l      (l_q),
      .r      (r_q),
      .k      (round_k),
      .l_next (l_next),
      .r_next (r_next)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= IDLE;
      else            state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = RUN;
         RUN:     if (round_q == 5'd0) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      busy      = (state == RUN);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         l_q     <= '0;
         r_q     <= '0;
         key_q   <= '0;
         round_q <= '0;
         plain   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  l_q     <= cipher[0:63];
                  r_q     <= cipher[64:127];
                  key_q   <= key;
                  round_q <= 5'(ROUNDS - 1);
               end
            end
            RUN: begin
               l_q <= l_next;
               r_q <= r_next;
               // The last round writes straight to plain so DONE follows immediately.
               if (round_q == 5'd0) plain <= {l_next, r_next};
               else                 round_q <= round_q - 5'd1;
            end
            default: ;
         endcase
      end
   end

`ifdef DECRYPTION_BLOCK_COUNT_EN
   logic [15:0] count_q;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         count_q <= '0;
      else if (out_valid && out_ready && (count_q != 16'hFFFF))
         count_q <= count_q + 16'd1;
   end

   assign block_count = count_q;
`else
   assign block_count = 16'h0000;
`endif

endmodule

// File: doc/decryption_core.md
# decryption_core

Iterative 32-round Feistel decryptor: the inverse of the team's `encrytion` block. It takes a 128-bit ciphertext and a 64-bit key through a valid/ready input handshake and returns the recovered 128-bit plaintext through a valid/ready output handshake. It runs one round per `sys_clk` cycle and sits beside the encryptor in the top level, on the 50 MHz system clock domain.

## Interface
- No parameters. Round count and rotation amounts are package constants.
- `sys_clk`  in  1  50 MHz system clock; all logic is on its rising edge.
- `sys_rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  `cipher` and `key` are valid.
- `in_ready`  out  1  block idle and able to accept; equals (state == IDLE).
- `cipher`  in  [0:127]  ciphertext; bit 0 is the MSB; L = [0:63], R = [64:127].
- `key`  in  [0:63]  key; bit 0 is the MSB.
- `out_valid`  out  1  `plain` holds a result; equals (state == DONE).
- `out_ready`  in  1  downstream accepts `plain`.
- `plain`  out  [0:127]  recovered plaintext, registered.
- `busy`  out  1  equals (state == RUN).
- `block_count`  out  16  completed-block counter; see Configuration.

## Operation
- Cipher definition. All of it is shared with the encryptor.
  - rotl64(x, n) is a 64-bit left rotate. All sums are mod 2^64.
  - Round key: K_i = rotl64(key, (3*i) mod 64) XOR i, with i zero-extended, for i = 0..31.
  - Round function: F(x, k) = rotl64(x + k, 13) XOR x.
  - Encrypt round i = 0..31: (L, R) <- (R, L XOR F(R, K_i)).
- Decrypt step for round i, run for i = 31 down to 0: (L, R) <- (R XOR F(L, K_i), L).
- FSM states are IDLE, RUN and DONE.
  - IDLE: when in_valid is high, capture {L, R} <- cipher and key_q <- key, set round <- 31, and go to RUN.
  - RUN: apply the decrypt step with K_round. If round == 0, load plain <- {L', R'} and go to DONE. Otherwise round <- round - 1.
  - DONE: hold plain. When out_ready is high, go to IDLE.
- `key` is sampled only at acceptance. Changes on `cipher` or `key` while not in IDLE are ignored.
- `in_ready` is low in DONE. A new block cannot be accepted on the same edge as the output handshake.
- The round key is computed combinationally from key_q and the 5-bit round counter. There is no key-schedule storage.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, busy 0, plain 0, block_count 0. All internal registers are 0.
- Input acceptance happens at edge E0, the first edge where in_valid and in_ready are both high.
- Rounds execute at edges E1..E32. `out_valid` is high from just after E32.
- Output handshake happens at the first edge ≥ E33 where out_ready is high. `in_ready` rises just after that edge.
- With out_ready held high, sustained throughput is one block per 34 cycles.
- `plain` is stable for as long as out_valid is high and out_ready is low. It is not cleared on the output handshake; it holds until the next DONE.
- Reset asserted in any state, including mid-RUN, forces the reset values immediately. The in-flight block is discarded and no output handshake occurs.
- Round counter: 5 bits, wraps never (exits at 0).

## Configuration
- `DECRYPTION_BLOCK_COUNT_EN`
- Defined:
  - `block_count` increments by 1 on every output handshake (out_valid & out_ready).
  - It saturates at 16'hFFFF.
  - It resets to 0 only on sys_rst_n.
- Undefined: `block_count` is tied to 16'h0000 and no counter register is built.

## Structure
- Shared package `cipher_pkg` holds:
  - constants ROUNDS = 32, F_ROT = 13 and KEY_ROT_STEP = 3;
  - functions rotl64, round_key(key, i) and round_f(x, k);
  - the state encoding IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
- The encryptor uses the same package, so both directions share one definition.
- One sub-module, `feistel_round_dec`: purely combinational (L, R, K) -> (L', R'). It is instantiated once and reused every cycle. The rest of the block is the FSM and registers.

## Test plan
- Round trip: key = 64'h0, plaintext = all ones. The bench gets C from the `encrytion` model and sends it. Required: `plain` = 128'hFFFF…FFFF, with out_valid rising exactly 32 cycles after acceptance.
- Random round trip: 1000 random (plaintext, key) pairs with out_ready held at 1. Required: every `plain` matches its input, with exactly 34 cycles between successive in_ready handshakes.
- Backpressure: out_ready held low for 10 cycles after DONE. Required: out_valid = 1, in_ready = 0 and `plain` unchanged across all 10 cycles; IDLE on the cycle after out_ready = 1.
- Input isolation: during RUN, toggle `key` to 64'hFFFF_FFFF_FFFF_FFFF and change `cipher`. Required: the result equals the decryption computed with the originally accepted values.
- Reset mid-run: assert sys_rst_n = 0 at round 15 for 2 cycles. Required: outputs take the reset values immediately and no spurious out_valid appears; the next block after release decrypts correctly.
- With `DECRYPTION_BLOCK_COUNT_EN`: 5 completed blocks give block_count = 5, and reset returns it to 0. Without the macro, block_count stays 0 throughout.
